mem_stage_ctrl: RTL and testbench

- MEM-stage controller between the EXE/MEM and MEM/WB pipeline registers; produces the `wb_en`, `mem_r_en`, ALU result, memory read value and destination that the MEM/WB register captures.
- Runs loads and stores against an external word SRAM through a req/ack handshake of variable latency.
- Freezes the upstream pipeline and sends bubbles downstream until the access completes.
- Non-memory instructions pass through combinationally with zero added latency.

---
 rtl/mem_stage_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_mem_stage_ctrl.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_ctrl.sv
// rtl/mem_stage_ctrl.sv - MEM-stage controller: SRAM load/store sequencing, pipeline freeze and MEM/WB outputs
//
// Sits between the EXE/MEM and MEM/WB pipeline registers.
//
// Non-memory instructions pass straight through with no added latency.
//
// Loads and stores go to a word SRAM over a req/ack handshake:
//   - an access takes 1 detect cycle (IDLE), N request cycles (REQ) and 1 result cycle (DONE);
//   - freeze stalls the upstream stages and bubbles go downstream until DONE.
//
// Optional feature macro: MEM_TIMEOUT_EN
//   - adds parameter TIMEOUT and output mem_err;
//   - an access that sees no ack within TIMEOUT request cycles is abandoned;
//   - the abandoned access completes with read data 32'hDEADBEEF and mem_err high.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   in_valid .. dest_in instruction fields from EXE/MEM
//   freeze              stall for IF..EXE/MEM
//   wb_en_out .. dest_out  values captured by MEM/WB
//   sram_req/we/addr/wdata  registered SRAM request
//   sram_ack/rdata      SRAM completion and read data
//   mem_err             timeout flag (MEM_TIMEOUT_EN only)

module mem_stage_ctrl #(
    parameter int DATA_W    = 32,
    parameter int REG_W     = 4,
    parameter int ADDR_W    = 16,
    parameter int BASE_ADDR = 1024
`ifdef MEM_TIMEOUT_EN
    ,
    parameter int TIMEOUT   = 255
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic              wb_en_in,
    input  logic              mem_r_en_in,
    input  logic              mem_w_en_in,
    input  logic [DATA_W-1:0] alu_result_in,
    input  logic [DATA_W-1:0] st_val_in,
    input  logic [REG_W-1:0]  dest_in,
    output logic              freeze,
    output logic              wb_en_out,
    output logic              mem_r_en_out,
    output logic [DATA_W-1:0] alu_result_out,
    output logic [DATA_W-1:0] mem_read_val_out,
    output logic [REG_W-1:0]  dest_out,
    output logic              sram_req,
    output logic              sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic              sram_ack,
    input  logic [DATA_W-1:0] sram_rdata
`ifdef MEM_TIMEOUT_EN
    ,
    output logic              mem_err
`endif
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [DATA_W-1:0] BASE = DATA_W'(BASE_ADDR);

    logic [1:0]        state;
    logic              lat_wb_en;
    logic              lat_mem_r_en;
    logic              lat_mem_w_en;
    logic [DATA_W-1:0] lat_alu_result;
    logic [REG_W-1:0]  lat_dest;
    logic [DATA_W-1:0] cap_data;
    logic              memop;

`ifdef MEM_TIMEOUT_EN
    logic [7:0] wait_cnt;
    logic [7:0] wait_cnt_next;
    assign wait_cnt_next = wait_cnt + 8'd1;
`endif

    assign memop = in_valid & (mem_r_en_in | mem_w_en_in);

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= ST_IDLE;
            sram_req       <= 1'b0;
            sram_we        <= 1'b0;
            sram_addr      <= '0;
            sram_wdata     <= '0;
            lat_wb_en      <= 1'b0;
            lat_mem_r_en   <= 1'b0;
            lat_mem_w_en   <= 1'b0;
            lat_alu_result <= '0;
            lat_dest       <= '0;
            cap_data       <= '0;
`ifdef MEM_TIMEOUT_EN
            wait_cnt       <= '0;
            mem_err        <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (memop) begin
                        lat_wb_en      <= wb_en_in;
                        lat_mem_r_en   <= mem_r_en_in;
                        lat_mem_w_en   <= mem_w_en_in;
                        lat_alu_result <= alu_result_in;
                        lat_dest       <= dest_in;
                        sram_req       <= 1'b1;
                        // A request with both enables set is issued as a write.
                        sram_we        <= mem_w_en_in;
                        // Byte address relative to the SRAM base, as a word index;
                        // addresses below the base wrap around the SRAM.
                        sram_addr      <= ADDR_W'((alu_result_in - BASE) >> 2);
                        sram_wdata     <= st_val_in;
                        state          <= ST_REQ;
`ifdef MEM_TIMEOUT_EN
                        wait_cnt       <= '0;
`endif
                    end
                end
                ST_REQ: begin
                    if (sram_ack) begin
                        cap_data <= (lat_mem_r_en && !lat_mem_w_en) ? sram_rdata : '0;
                        sram_req <= 1'b0;
                        sram_we  <= 1'b0;
                        state    <= ST_DONE;
`ifdef MEM_TIMEOUT_EN
                    end else if (wait_cnt_next == 8'(TIMEOUT)) begin
                        cap_data <= DATA_W'(32'hDEADBEEF);
                        sram_req <= 1'b0;
                        sram_we  <= 1'b0;
                        mem_err  <= 1'b1;
                        state    <= ST_DONE;
                    end else begin
                        wait_cnt <= wait_cnt_next;
`endif
                    end
                end
                ST_DONE: begin
                    // EXE/MEM still holds the finished instruction here; never restart from DONE.
                    state <= ST_IDLE;
`ifdef MEM_TIMEOUT_EN
                    mem_err <= 1'b0;
`endif
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        freeze           = 1'b0;
        wb_en_out        = 1'b0;
        mem_r_en_out     = 1'b0;
        alu_result_out   = '0;
        mem_read_val_out = '0;
        dest_out         = '0;
        case (state)
            ST_IDLE: begin
                if (memop) begin
                    freeze = 1'b1;
                end else begin
                    wb_en_out      = in_valid & wb_en_in;
                    mem_r_en_out   = in_valid & mem_r_en_in;
                    alu_result_out = alu_result_in;
                    dest_out       = dest_in;
                end
            end
            ST_REQ: begin
                freeze = 1'b1;
            end
            ST_DONE: begin
                wb_en_out        = lat_wb_en;
                mem_r_en_out     = lat_mem_r_en;
                alu_result_out   = lat_alu_result;
                mem_read_val_out = cap_data;
                dest_out         = lat_dest;
            end
            default: begin
                freeze = 1'b0;
            end
        endcase
        if (reset) begin
            freeze       = 1'b0;
            wb_en_out    = 1'b0;
            mem_r_en_out = 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb/tb_mem_stage_ctrl.sv - scoreboard bench for mem_stage_ctrl
module tb_mem_stage_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, wb_en_in, mem_r_en_in, mem_w_en_in;
    logic [31:0] alu_result_in, st_val_in;
    logic [3:0]  dest_in;
    logic        freeze, wb_en_out, mem_r_en_out;
    logic [31:0] alu_result_out, mem_read_val_out;
    logic [3:0]  dest_out;
    logic        sram_req, sram_we;
    logic [15:0] sram_addr;
    logic [31:0] sram_wdata;
    logic        sram_ack;
    logic [31:0] sram_rdata;
`ifdef MEM_TIMEOUT_EN
    logic        mem_err;
`endif

    mem_stage_ctrl dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .wb_en_in(wb_en_in),
        .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in),
        .alu_result_in(alu_result_in), .st_val_in(st_val_in), .dest_in(dest_in),
        .freeze(freeze), .wb_en_out(wb_en_out), .mem_r_en_out(mem_r_en_out),
        .alu_result_out(alu_result_out), .mem_read_val_out(mem_read_val_out),
        .dest_out(dest_out), .sram_req(sram_req), .sram_we(sram_we),
        .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_ack(sram_ack),
        .sram_rdata(sram_rdata)
`ifdef MEM_TIMEOUT_EN
        , .mem_err(mem_err)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] addr;
        logic        we;
        logic [31:0] wdata;
        int          frz;
        logic        wb;
        logic        mr;
        logic [31:0] alu;
        logic [31:0] rval;
        logic [3:0]  dest;
    } exp_t;

    exp_t sb[$];

    int vectors = 0;
    int miscompares = 0;

    int          obs_frz;
    logic        obs_bubble;
    logic        obs_req, obs_we, obs_req_done, obs_we_done;
    logic [15:0] obs_addr;
    logic [31:0] obs_wdata, obs_alu, obs_rval;
    logic        obs_wb, obs_mr;
    logic [3:0]  obs_dest;

    task automatic set_idle_inputs();
        in_valid = 0; wb_en_in = 0; mem_r_en_in = 0; mem_w_en_in = 0;
        alu_result_in = 0; st_val_in = 0; dest_in = 0;
    endtask

    // Drives one load/store; lat = REQ cycle in which ack is given (1 = first).
    task automatic mem_access(input logic rd, input logic wr, input logic wb,
                              input logic [31:0] alu, input logic [31:0] st,
                              input logic [3:0] dst, input int lat,
                              input logic [31:0] rdata);
        exp_t e;
        logic [31:0] diff;
        diff    = alu - 32'd1024;
        e.addr  = diff[17:2];
        e.we    = wr;
        e.wdata = st;
        e.frz   = 1 + lat;
        e.wb    = wb;
        e.mr    = rd;
        e.alu   = alu;
        e.rval  = (rd && !wr) ? rdata : 32'h0;
        e.dest  = dst;
        sb.push_back(e);

        in_valid = 1; wb_en_in = wb; mem_r_en_in = rd; mem_w_en_in = wr;
        alu_result_in = alu; st_val_in = st; dest_in = dst;
        obs_frz = 0;
        @(negedge clk);
        obs_frz += int'(freeze);
        obs_bubble = wb_en_out | mem_r_en_out | (|dest_out) | (|alu_result_out);
        @(posedge clk); #1;
        obs_req = sram_req; obs_we = sram_we; obs_addr = sram_addr; obs_wdata = sram_wdata;
        for (int k = 1; k <= 200; k++) begin
            if (k == lat) begin
                sram_ack = 1;
                sram_rdata = rdata;
            end
            @(negedge clk);
            obs_frz += int'(freeze);
            @(posedge clk); #1;
            sram_ack = 0;
            sram_rdata = $urandom;
            if (k == lat) break;
        end
        @(negedge clk);
        obs_frz += int'(freeze);
        obs_wb = wb_en_out; obs_mr = mem_r_en_out; obs_alu = alu_result_out;
        obs_rval = mem_read_val_out; obs_dest = dest_out;
        obs_req_done = sram_req; obs_we_done = sram_we;
        set_idle_inputs();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset = 1;
        in_valid = 1; mem_r_en_in = 1; wb_en_in = 1; alu_result_in = 32'd1032; dest_in = 4'd5;
        @(posedge clk); #1;
        @(negedge clk);
        vectors++;
        if (freeze !== 1'b0) begin miscompares++; $display("FAIL reset_freeze got=%b exp=0", freeze); end
        vectors++;
        if (wb_en_out !== 1'b0 || mem_r_en_out !== 1'b0) begin
            miscompares++; $display("FAIL reset_wb_mr got=%b%b exp=00", wb_en_out, mem_r_en_out);
        end
        vectors++;
        if ({sram_req, sram_we, sram_addr, sram_wdata} !== 50'h0) begin
            miscompares++;
            $display("FAIL reset_sram got req=%b we=%b addr=%h wdata=%h exp=all 0", sram_req, sram_we, sram_addr, sram_wdata);
        end
        set_idle_inputs();
        @(posedge clk); #1;
        reset = 0;
    endtask

    task automatic test_passthrough();
        in_valid = 1; wb_en_in = 1; alu_result_in = 32'h7; dest_in = 4'd3;
        #1;
        vectors++;
        if ({wb_en_out, alu_result_out, dest_out, freeze} !== {1'b1, 32'h7, 4'd3, 1'b0}) begin
            miscompares++;
            $display("FAIL passthru got wb=%b alu=%h dest=%0d frz=%b exp wb=1 alu=7 dest=3 frz=0", wb_en_out, alu_result_out, dest_out, freeze);
        end
        @(posedge clk); #1;
        vectors++;
        if (sram_req !== 1'b0) begin miscompares++; $display("FAIL passthru_req got=%b exp=0", sram_req); end
        in_valid = 0;
        #1;
        vectors++;
        if (wb_en_out !== 1'b0) begin miscompares++; $display("FAIL invalid_wb got=%b exp=0", wb_en_out); end
        set_idle_inputs();
        @(posedge clk); #1;
    endtask

    task automatic test_load();
        exp_t e;
        mem_access(1, 0, 1, 32'd1032, 32'h0, 4'd5, 3, 32'hCAFEF00D);
        e = sb.pop_front();
        vectors++;
        if (obs_addr !== e.addr || obs_we !== e.we || obs_req !== 1'b1) begin
            miscompares++; $display("FAIL load_req got addr=%h we=%b req=%b exp addr=%h we=%b req=1", obs_addr, obs_we, obs_req, e.addr, e.we);
        end
        vectors++;
        if (obs_frz !== e.frz) begin miscompares++; $display("FAIL load_freeze got=%0d exp=%0d", obs_frz, e.frz); end
        vectors++;
        if (obs_bubble !== 1'b0) begin miscompares++; $display("FAIL load_bubble got=%b exp=0", obs_bubble); end
        vectors++;
        if ({obs_rval, obs_dest, obs_mr, obs_wb, obs_alu} !== {e.rval, e.dest, e.mr, e.wb, e.alu}) begin
            miscompares++;
            $display("FAIL load_done got rval=%h dest=%0d mr=%b wb=%b alu=%h exp rval=%h dest=%0d mr=%b wb=%b alu=%h",
                     obs_rval, obs_dest, obs_mr, obs_wb, obs_alu, e.rval, e.dest, e.mr, e.wb, e.alu);
        end
        vectors++;
        if (obs_req_done !== 1'b0) begin miscompares++; $display("FAIL load_req_clear got=%b exp=0", obs_req_done); end
    endtask

    task automatic test_store();
        exp_t e;
        mem_access(0, 1, 0, 32'd1024, 32'h12345678, 4'd0, 1, 32'h55AA55AA);
        e = sb.pop_front();
        vectors++;
        if (obs_addr !== e.addr || obs_we !== e.we || obs_wdata !== e.wdata) begin
            miscompares++; $display("FAIL store_req got addr=%h we=%b wdata=%h exp addr=%h we=%b wdata=%h", obs_addr, obs_we, obs_wdata, e.addr, e.we, e.wdata);
        end
        vectors++;
        if (obs_frz !== e.frz) begin miscompares++; $display("FAIL store_freeze got=%0d exp=%0d", obs_frz, e.frz); end
        vectors++;
        if (obs_wb !== e.wb || obs_rval !== e.rval || obs_we_done !== 1'b0) begin
            miscompares++; $display("FAIL store_done got wb=%b rval=%h we=%b exp wb=%b rval=%h we=0", obs_wb, obs_rval, obs_we_done, e.wb, e.rval);
        end
    endtask

    task automatic test_rd_wr_both();
        exp_t e;
        mem_access(1, 1, 1, 32'd1040, 32'hA5A5A5A5, 4'd9, 2, 32'h11112222);
        e = sb.pop_front();
        vectors++;
        if (obs_we !== e.we || obs_addr !== e.addr || obs_mr !== e.mr || obs_rval !== e.rval) begin
            miscompares++; $display("FAIL both_en got we=%b addr=%h mr=%b rval=%h exp we=%b addr=%h mr=%b rval=%h", obs_we, obs_addr, obs_mr, obs_rval, e.we, e.addr, e.mr, e.rval);
        end
    endtask

    task automatic test_wrap_stray_ack();
        exp_t e;
        sram_ack = 1; sram_rdata = 32'hBADBAD00;
        @(posedge clk); #1;
        sram_ack = 0;
        vectors++;
        if (sram_req !== 1'b0 || freeze !== 1'b0) begin
            miscompares++; $display("FAIL stray_ack got req=%b frz=%b exp req=0 frz=0", sram_req, freeze);
        end
        mem_access(1, 0, 1, 32'd1020, 32'h0, 4'd7, 2, 32'h0BADF00D);
        e = sb.pop_front();
        vectors++;
        if (obs_addr !== e.addr) begin miscompares++; $display("FAIL wrap_addr got=%h exp=%h", obs_addr, e.addr); end
        vectors++;
        if (obs_rval !== e.rval || obs_frz !== e.frz) begin
            miscompares++; $display("FAIL wrap_done got rval=%h frz=%0d exp rval=%h frz=%0d", obs_rval, obs_frz, e.rval, e.frz);
        end
    endtask

    task automatic test_reset_mid_req();
        exp_t e;
        in_valid = 1; mem_r_en_in = 1; wb_en_in = 1; alu_result_in = 32'd1100; dest_in = 4'd2;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1;
        @(negedge clk);
        vectors++;
        if (freeze !== 1'b0 || wb_en_out !== 1'b0) begin
            miscompares++; $display("FAIL rst_hold got frz=%b wb=%b exp 0 0", freeze, wb_en_out);
        end
        @(posedge clk); #1;
        reset = 0;
        set_idle_inputs();
        #1;
        vectors++;
        if (sram_req !== 1'b0 || freeze !== 1'b0 || wb_en_out !== 1'b0) begin
            miscompares++; $display("FAIL rst_mid got req=%b frz=%b wb=%b exp 0 0 0", sram_req, freeze, wb_en_out);
        end
        @(posedge clk); #1;
        mem_access(1, 0, 1, 32'd1048, 32'h0, 4'd6, 2, 32'h600DCAFE);
        e = sb.pop_front();
        vectors++;
        if (obs_addr !== e.addr || obs_rval !== e.rval || obs_dest !== e.dest || obs_frz !== e.frz) begin
            miscompares++;
            $display("FAIL rst_after_load got addr=%h rval=%h dest=%0d frz=%0d exp addr=%h rval=%h dest=%0d frz=%0d",
                     obs_addr, obs_rval, obs_dest, obs_frz, e.addr, e.rval, e.dest, e.frz);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        logic [31:0] a;
        logic [31:0] d;
        for (int i = 0; i < 4; i++) begin
            a = 32'd1024 + 32'($urandom_range(0, 4000)) * 4;
            d = $urandom;
            mem_access(1, 0, 1, a, 32'h0, 4'(i + 8), 1 + (i % 3), d);
            e = sb.pop_front();
            vectors++;
            if (obs_addr !== e.addr || obs_rval !== e.rval || obs_dest !== e.dest || obs_frz !== e.frz || obs_alu !== e.alu) begin
                miscompares++;
                $display("FAIL b2b_%0d got addr=%h rval=%h dest=%0d frz=%0d alu=%h exp addr=%h rval=%h dest=%0d frz=%0d alu=%h",
                         i, obs_addr, obs_rval, obs_dest, obs_frz, obs_alu, e.addr, e.rval, e.dest, e.frz, e.alu);
            end
        end
    endtask

    initial begin
        reset = 1;
        sram_ack = 0;
        sram_rdata = 0;
        set_idle_inputs();
        @(posedge clk); #1;
        test_reset();
        test_passthrough();
        test_load();
        test_store();
        test_rd_wr_both();
        test_wrap_stray_ack();
        test_reset_mid_req();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
